// File: rtl/ictrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default
// register addresses and the vector width.
package ictrl_pkg;

  localparam int VEC_W = 3;

  localparam logic [15:0] MASK_ADDR_DEF = 16'hFFF0;
  localparam logic [15:0] PEND_ADDR_DEF = 16'hFFF1;
  localparam logic [15:0] OVF_ADDR_DEF  = 16'hFFF2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } ictrl_state_e;

endpackage

// File: rtl/interrupt_controller_prio_encoder.sv
// Lowest-index-first priority encoder: N_IRQ request bits to a VEC_W-bit index.
module prio_encoder
  import ictrl_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] req,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = VEC_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing, maskable interrupt controller with ack/done CPU handshake.
// Optional overflow (lost interrupt) register enabled by macro ICTRL_OVF_EN.
//
//   state | meaning
//   IDLE  | waiting for an unmasked pending source
//   REQ   | int_req high, waiting for int_ack (or for the source to be masked)
//   SVC   | handler running, no new request until int_done
module interrupt_controller
  import ictrl_pkg::*;
#(
  parameter int          N_IRQ     = 8,
  parameter logic [15:0] MASK_ADDR = MASK_ADDR_DEF,
  parameter logic [15:0] PEND_ADDR = PEND_ADDR_DEF,
  parameter logic [15:0] OVF_ADDR  = OVF_ADDR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vector,
  input  logic             int_ack,
  input  logic             int_done,
  input  logic [15:0]      bus_addr,
  input  logic             bus_we,
  input  logic [7:0]       bus_wdata,
  output logic [7:0]       bus_rdata,
  output logic             bus_hit
);

  ictrl_state_e     state;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] pending_n;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] mask_n;
  logic [N_IRQ-1:0] sel_oh;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] pend_w1c;
  logic [N_IRQ-1:0] ovf_rd;
  logic [VEC_W-1:0] win_idx;
  logic             win_valid;
  logic             mask_keep;
  logic             addr_is_mask;
  logic             addr_is_pend;
  logic             addr_is_ovf;
  logic             hit_ovf;
  logic [7:0]       rdata_n;

  assign addr_is_mask = (bus_addr == MASK_ADDR);
  assign addr_is_pend = (bus_addr == PEND_ADDR);
  assign addr_is_ovf  = (bus_addr == OVF_ADDR);

  assign irq_edge = irq_in & ~irq_prev;
  assign mask_n   = (bus_we && addr_is_mask) ? bus_wdata[N_IRQ-1:0] : mask;
  assign pend_w1c = (bus_we && addr_is_pend) ? bus_wdata[N_IRQ-1:0] : '0;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      sel_oh[i] = (int_vector == VEC_W'(i));
    end
  end

  assign ack_clr   = (state == REQ && int_ack) ? sel_oh : '0;
  // Clears first, then set: a fresh edge always survives a same-cycle clear.
  assign pending_n = (pending & ~(ack_clr | pend_w1c)) | irq_edge;
  assign mask_keep = |(mask_n & sel_oh);

  prio_encoder #(
    .N_IRQ(N_IRQ)
  ) u_prio (
    .req  (pending & mask),
    .idx  (win_idx),
    .valid(win_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '1;
    end else begin
      irq_prev <= irq_in;
      pending  <= pending_n;
      mask     <= mask_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vector <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            int_vector <= win_idx;
            int_req    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            state   <= SVC;
          end else if (!mask_keep) begin
            int_req <= 1'b0;
            state   <= IDLE;
          end
        end
        SVC: begin
          if (int_done) state <= IDLE;
        end
        default: begin
          int_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef ICTRL_OVF_EN
  logic [N_IRQ-1:0] ovf;
  logic [N_IRQ-1:0] ovf_w1c;

  assign ovf_w1c = (bus_we && addr_is_ovf) ? bus_wdata[N_IRQ-1:0] : '0;

  // An edge landing on an already-pending source means one request was lost.
  always_ff @(posedge clk) begin
    if (reset) ovf <= '0;
    else       ovf <= (ovf & ~ovf_w1c) | (irq_edge & pending);
  end

  assign ovf_rd  = ovf;
  assign hit_ovf = addr_is_ovf;
`else
  assign ovf_rd  = '0;
  assign hit_ovf = 1'b0;
`endif

  assign bus_hit = addr_is_mask | addr_is_pend | hit_ovf;

  always_comb begin
    rdata_n = '0;
    if (addr_is_mask)      rdata_n[N_IRQ-1:0] = mask;
    else if (addr_is_pend) rdata_n[N_IRQ-1:0] = pending;
    else if (addr_is_ovf)  rdata_n[N_IRQ-1:0] = ovf_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) bus_rdata <= '0;
    else       bus_rdata <= rdata_n;
  end

endmodule
